// File: rtl/irq_dispatch.sv
// Dispatch stage behind the interrupt priority arbiter: registers the winning
// candidate, raises a held request to the core, claims on handshake, nests levels.
module irq_dispatch #(
  parameter  int NrIrqs     = 32,
  parameter  int PrioWidth  = 8,
  parameter  int StackDepth = 4,
  localparam int IdxWidth   = $clog2(NrIrqs),
  localparam int DepthW     = $clog2(StackDepth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 arb_valid_i,
  input  logic [PrioWidth-1:0] arb_prio_i,
  input  logic [IdxWidth-1:0]  arb_idx_i,
  input  logic [PrioWidth-1:0] thresh_i,
  output logic                 irq_valid_o,
  output logic [IdxWidth-1:0]  irq_id_o,
  output logic [PrioWidth-1:0] irq_prio_o,
  input  logic                 irq_ready_i,
  input  logic                 complete_i,
  output logic [NrIrqs-1:0]    claim_o,
  output logic [PrioWidth-1:0] level_o,
  output logic [DepthW-1:0]    depth_o
);

  typedef struct packed {
    logic                 valid;
    logic [PrioWidth-1:0] prio;
    logic [IdxWidth-1:0]  idx;
  } cand_t;

  typedef enum logic [1:0] {IDLE, REQ, SETTLE} state_t;

  cand_t                               cand_q;
  state_t                              state_q;
  logic [StackDepth-1:0][PrioWidth-1:0] stack_q;
  logic [DepthW-1:0]                   depth_q;
  logic [PrioWidth-1:0]                level;
  logic                                dispatch_ok;
  logic                                handshake;
  logic                                push;
  logic                                pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) cand_q <= '0;
    else       cand_q <= '{valid: arb_valid_i, prio: arb_prio_i, idx: arb_idx_i};
  end

  always_comb begin
    level = '0;
    for (int i = 0; i < StackDepth; i++)
      if (depth_q == DepthW'(i + 1)) level = stack_q[i];
  end

  assign dispatch_ok = cand_q.valid && (cand_q.prio > thresh_i) && (cand_q.prio > level) &&
                       (depth_q < DepthW'(StackDepth));
  assign handshake   = irq_valid_o && irq_ready_i;
  assign push        = handshake;
  assign pop         = complete_i && (depth_q != '0);
  assign claim_o     = handshake ? (NrIrqs'(1) << irq_id_o) : '0;
  assign level_o     = level;
  assign depth_o     = depth_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      irq_valid_o <= 1'b0;
      irq_id_o    <= '0;
      irq_prio_o  <= '0;
    end else begin
      case (state_q)
        IDLE: if (dispatch_ok) begin
          state_q     <= REQ;
          irq_valid_o <= 1'b1;
          irq_id_o    <= cand_q.idx;
          irq_prio_o  <= cand_q.prio;
        end
        REQ: if (irq_ready_i) begin
          state_q     <= SETTLE;
          irq_valid_o <= 1'b0;
        end
        // candidate register still holds the pre-claim arbiter result here
        SETTLE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // pop-then-push when both happen: top entry is replaced, depth unchanged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stack_q <= '0;
      depth_q <= '0;
    end else begin
      for (int i = 0; i < StackDepth; i++) begin
        if (push && pop && depth_q == DepthW'(i + 1))  stack_q[i] <= irq_prio_o;
        else if (push && !pop && depth_q == DepthW'(i)) stack_q[i] <= irq_prio_o;
      end
      if (push && !pop && depth_q < DepthW'(StackDepth)) depth_q <= depth_q + 1'b1;
      else if (pop && !push)                             depth_q <= depth_q - 1'b1;
    end
  end

endmodule
